mul_share_arbiter: RTL

- Shares one registered 8x8 array multiplier among NREQ requesters.
- Arbitrates each cycle with round-robin priority and drives the granted operands onto the multiplier inputs.
- Tracks each in-flight operation with a tag pipeline aligned to the multiplier latency, and returns each 16-bit product to its originating requester.
- Sits between client blocks and the multiplier; the multiplier is instantiated outside this block.

---
 rtl/mul_share_arbiter.sv | 77 +++++++
 1 files changed

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one pipelined 8x8 multiplier among NREQ requesters
module mul_share_arbiter #(
  parameter int NREQ = 4,
  parameter int MUL_LATENCY = 2,
  parameter int CNT_W = 16,
  localparam int IDW = NREQ > 1 ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pause,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic [7:0]        mul_a,
  output logic [7:0]        mul_b,
  input  logic [15:0]       mul_p,
  output logic              resp_valid,
  output logic [IDW-1:0]    resp_id,
  output logic [15:0]       resp_p,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);
  logic [IDW-1:0] ptr_q, ptr_d, g, idx;
  logic hit;
  logic [MUL_LATENCY-1:0] vld_q;
  logic [IDW-1:0] id_q [MUL_LATENCY];
  logic resp_valid_q;
  logic [IDW-1:0] resp_id_q;
  logic [15:0] resp_p_q;
  logic [CNT_W-1:0] cnt_q;
  always_comb begin
    hit = 1'b0;
    g = '0;
    idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(ptr_q) + k) % NREQ);
      if (!hit && !pause && req_valid[idx]) begin
        hit = 1'b1;
        g = idx;
      end
    end
  end
  assign req_ready = hit ? NREQ'(1) << g : '0;
  assign mul_a = hit ? req_a[{g, 3'b000} +: 8] : 8'd0;
  assign mul_b = hit ? req_b[{g, 3'b000} +: 8] : 8'd0;
  assign ptr_d = hit ? (g == IDW'(NREQ - 1) ? '0 : g + 1'b1) : ptr_q;
  // tag tail lines up with mul_p; the response register adds one more stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      vld_q <= '0;
      for (int i = 0; i < MUL_LATENCY; i++) id_q[i] <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q <= '0;
      resp_p_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      vld_q[0] <= hit;
      id_q[0] <= g;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        id_q[i] <= id_q[i-1];
      end
      resp_valid_q <= vld_q[MUL_LATENCY-1];
      resp_id_q <= id_q[MUL_LATENCY-1];
      if (vld_q[MUL_LATENCY-1]) resp_p_q <= mul_p;
      if (vld_q[MUL_LATENCY-1] && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end
  end
  assign resp_valid = resp_valid_q;
  assign resp_id = resp_id_q;
  assign resp_p = resp_p_q;
  assign op_count = cnt_q;
  assign busy = |req_valid | |vld_q | resp_valid_q;
endmodule
